// File: rtl/ws2812_pixel_rx.sv
// ws2812_pixel_rx: one-wire WS2812-style LED-string receiver.
// Decodes pulse-width-coded bits into 24-bit GRB pixels, counts pixels per
// frame, detects the latch gap and forwards the stream after its own pixel.
//
// Ports
//   wb_clk_i      system clock
//   wb_rst_i      synchronous reset, active-high
//   din           asynchronous serial line from the pad
//   dout          forwarded serial line (registered copy of din_s)
//   pixel_data    last decoded pixel {G,R,B}
//   pixel_valid   1-cycle pulse qualifying pixel_data / pixel_index
//   pixel_index   0-based index of pixel_data in the current frame
//   frame_done    1-cycle pulse at the latch gap
//   frame_pixels  complete pixels in the last frame
//   overflow      sticky: more than MAX_PIXELS pixels in a frame
//   error         sticky: glitch, overlong high, or partial pixel at latch
//   clear         clears error and overflow
//
// state  | meaning
// S_SYNC | lost or unknown framing; wait for T_RESET clocks of low
// S_IDLE | between frames; wait for the first rising edge
// S_HIGH | measuring a high pulse
// S_LOW  | measuring the low time after a bit
module ws2812_pixel_rx #(
  parameter int T_MIN_HIGH = 4,
  parameter int T_THRESH   = 24,
  parameter int T_MAX_HIGH = 60,
  parameter int T_RESET    = 2000,
  parameter int MAX_PIXELS = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        din,
  output logic        dout,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  frame_pixels,
  output logic        overflow,
  output logic        error,
  input  logic        clear
);

  localparam int WW = $clog2(T_RESET + 1);
  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_MIN = WW'(T_MIN_HIGH);
  localparam logic [WW-1:0] W_THR = WW'(T_THRESH);
  localparam logic [WW-1:0] W_MAX = WW'(T_MAX_HIGH);
  localparam logic [WW-1:0] W_RST = WW'(T_RESET);
  localparam logic [7:0]    PIX_MAX = 8'(MAX_PIXELS);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_din_m, r_din_s, r_din_d;
  logic [WW-1:0] r_width, w_width_nxt;
  logic [23:0]   r_shift;
  logic [4:0]    r_bit_cnt;
  logic [7:0]    r_pix_cnt;
  logic          r_fwd_en;
  logic          w_rise, w_fall, w_shift, w_bit_val, w_latch, w_err_evt, w_pix_done;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_din_m <= 1'b0;
      r_din_s <= 1'b0;
      r_din_d <= 1'b0;
    end else begin
      r_din_m <= din;
      r_din_s <= r_din_m;
      r_din_d <= r_din_s;
    end
  end

  assign w_rise     = r_din_s & ~r_din_d;
  assign w_fall     = ~r_din_s & r_din_d;
  assign w_bit_val  = (r_width >= W_THR);
  assign w_pix_done = (r_bit_cnt == 5'd24);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_SYNC;
      r_width <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_width <= w_width_nxt;
    end
  end

  // A latch is taken once the registered low count has reached T_RESET, so a
  // rising edge arriving in that same clock closes the frame and starts a bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC: if (r_width >= W_RST) w_state_nxt = w_rise ? S_HIGH : S_IDLE;
      S_IDLE: if (w_rise) w_state_nxt = S_HIGH;
      S_HIGH: begin
        if (w_fall) w_state_nxt = (r_width < W_MIN) ? S_SYNC : S_LOW;
        else if (r_width >= W_MAX) w_state_nxt = S_SYNC;
      end
      S_LOW: begin
        if (r_width >= W_RST) w_state_nxt = w_rise ? S_HIGH : S_IDLE;
        else if (w_rise) w_state_nxt = S_HIGH;
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // r_width counts the clocks of the current level already seen; the clock
  // that detects an edge counts as the first clock of the new level.
  always_comb begin
    w_width_nxt = r_width;
    w_shift     = 1'b0;
    w_latch     = 1'b0;
    w_err_evt   = 1'b0;
    case (r_state)
      S_SYNC: begin
        if (r_width >= W_RST && w_rise) w_width_nxt = W_ONE;
        else if (r_din_s) w_width_nxt = '0;
        else if (r_width < W_RST) w_width_nxt = r_width + W_ONE;
      end
      S_IDLE: if (w_rise) w_width_nxt = W_ONE;
      S_HIGH: begin
        if (w_fall) begin
          if (r_width < W_MIN) begin
            w_err_evt   = 1'b1;
            w_width_nxt = '0;
          end else begin
            w_shift     = 1'b1;
            w_width_nxt = W_ONE;
          end
        end else if (r_width >= W_MAX) begin
          w_err_evt   = 1'b1;
          w_width_nxt = '0;
        end else begin
          w_width_nxt = r_width + W_ONE;
        end
      end
      S_LOW: begin
        if (r_width >= W_RST) w_latch = 1'b1;
        if (w_rise) w_width_nxt = W_ONE;
        else if (r_width < W_RST) w_width_nxt = r_width + W_ONE;
      end
      default: w_width_nxt = '0;
    endcase
  end

  // Later assignments take priority: an error event beats clear and any
  // simultaneous completion bookkeeping.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_fwd_en     <= 1'b0;
      dout         <= 1'b0;
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      overflow     <= 1'b0;
      error        <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (clear) begin
        error    <= 1'b0;
        overflow <= 1'b0;
      end
      if (w_shift) begin
        r_shift   <= {r_shift[22:0], w_bit_val};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_pix_done) begin
        pixel_valid <= 1'b1;
        pixel_data  <= r_shift;
        pixel_index <= r_pix_cnt;
        r_bit_cnt   <= '0;
        r_fwd_en    <= 1'b1;
        if (r_pix_cnt == PIX_MAX) overflow <= 1'b1;
        else r_pix_cnt <= r_pix_cnt + 8'd1;
      end
      if (w_latch) begin
        frame_done   <= 1'b1;
        frame_pixels <= r_pix_cnt;
        r_pix_cnt    <= '0;
        r_bit_cnt    <= '0;
        r_fwd_en     <= 1'b0;
        if (r_bit_cnt != 5'd0) error <= 1'b1;
      end
      if (w_err_evt) begin
        error     <= 1'b1;
        r_bit_cnt <= '0;
        r_pix_cnt <= '0;
        r_fwd_en  <= 1'b0;
      end
      dout <= r_fwd_en & r_din_s & ~w_latch & ~w_err_evt & (r_state != S_SYNC);
    end
  end

endmodule
